fft16_top_minimal: RTL and testbench

FFT16_TOP_MINIMAL -- requirements
Module: fft16_top_minimal

---
 rtl/fft16_top_minimal.sv | 45 ++++
 tb/tb_fft16_top_minimal.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fft16_top_minimal.sv
// fft16_top_minimal: 16-entry real sample memory feeding the first W^0 radix-2 DIT stage of a 16-point FFT.
// Define FFT16_ST1_SCALE_EN to halve every butterfly result (floor) instead of wrapping to 16 bits.
module fft16_top_minimal (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [3:0]   addr_in,
    input  logic [15:0]  xr_in,
    output logic [255:0] st1_yr,
    output logic [255:0] st1_yi
);
    logic signed [15:0] r_x [16];
    logic [255:0] r_yr;
    logic [255:0] w_yr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) r_x[i] <= '0;
        end else if (load) begin
            r_x[addr_in] <= xr_in;
        end
    end
    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_bfly
            logic signed [16:0] w_sum;
            logic signed [16:0] w_dif;
            assign w_sum = {r_x[k][15], r_x[k]} + {r_x[k+8][15], r_x[k+8]};
            assign w_dif = {r_x[k][15], r_x[k]} - {r_x[k+8][15], r_x[k+8]};
`ifdef FFT16_ST1_SCALE_EN
            assign w_yr[32*k +: 16]    = w_sum[16:1];
            assign w_yr[32*k+16 +: 16] = w_dif[16:1];
`else
            assign w_yr[32*k +: 16]    = w_sum[15:0];
            assign w_yr[32*k+16 +: 16] = w_dif[15:0];
`endif
        end
    endgenerate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_yr <= '0;
        else      r_yr <= w_yr;
    end
    assign st1_yr = r_yr;
    // Input is real-only and every twiddle is W^0, so the imaginary path is identically zero.
    assign st1_yi = '0;
endmodule

// File: tb/tb_fft16_top_minimal.sv
// tb_fft16_top_minimal: directed + random checks of the stage-1 butterflies against an integer model.
module tb_fft16_top_minimal;
    logic         clk;
    logic         rst;
    logic         load;
    logic [3:0]   addr_in;
    logic [15:0]  xr_in;
    logic [255:0] st1_yr;
    logic [255:0] st1_yi;
    int tests = 0;
    int fails = 0;
    int mem [16];

    fft16_top_minimal dut (
        .clk(clk), .rst(rst), .load(load), .addr_in(addr_in),
        .xr_in(xr_in), .st1_yr(st1_yr), .st1_yi(st1_yi)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_y(int i);
        int a, b, s;
        a = mem[i / 2];
        b = mem[i / 2 + 8];
        s = (i % 2) ? a - b : a + b;
`ifdef FFT16_ST1_SCALE_EN
        s = s >>> 1;
`endif
        return s[15:0];
    endfunction

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_y%0d", tag, i), st1_yr[16*i +: 16], exp_y(i));
        tests++;
        assert (st1_yi === 256'b0) else begin
            fails++;
            $error("FAIL %s_yi got=%h exp=0", tag, st1_yi);
        end
    endtask

    task automatic write(int a, logic [15:0] v);
        @(negedge clk);
        load = 1; addr_in = a[3:0]; xr_in = v;
        mem[a] = int'($signed(v));
        @(negedge clk);
        load = 0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mem[i] = 0;
    endtask

    task automatic ramp(string tag);
        int e;
        for (int n = 0; n < 16; n++) write(n, n[15:0]);
        @(negedge clk);
        check_all(tag);
        for (int k = 0; k < 8; k++) begin
`ifdef FFT16_ST1_SCALE_EN
            e = k + 4;
            check($sformatf("%s_even%0d", tag, k), st1_yr[32*k +: 16], e[15:0]);
            check($sformatf("%s_odd%0d", tag, k), st1_yr[32*k+16 +: 16], 16'hFFFC);
`else
            e = 2 * k + 8;
            check($sformatf("%s_even%0d", tag, k), st1_yr[32*k +: 16], e[15:0]);
            check($sformatf("%s_odd%0d", tag, k), st1_yr[32*k+16 +: 16], 16'hFFF8);
`endif
        end
    endtask

    task automatic async_reset_check(string tag);
        #2 rst = 0;
        #1;
        clear_model();
        tests++;
        assert (st1_yr === 256'b0 && st1_yi === 256'b0) else begin
            fails++;
            $error("FAIL %s got=%h exp=0", tag, st1_yr);
        end
    endtask

    initial begin
        rst = 0; load = 0; addr_in = 0; xr_in = 0;
        clear_model();
        #12;
        check_all("reset");
        @(negedge clk) rst = 1;

        ramp("ramp");

        @(negedge clk);
        async_reset_check("async_rst");
        @(negedge clk) rst = 1;
        @(negedge clk);
        check_all("post_rst");

        write(0, 16'd100);
        check("lat_before_y0", st1_yr[15:0], 16'd0);
        check("lat_before_y1", st1_yr[31:16], 16'd0);
        @(negedge clk);
        check("lat_y0", st1_yr[15:0], 16'd100);
        check("lat_y1", st1_yr[31:16], 16'd100);
        check_all("lat");

        @(negedge clk);
        load = 0; addr_in = 4'd3; xr_in = 16'd500;
        @(negedge clk);
        @(negedge clk);
        check_all("gate");

        write(0, 16'd0);
        write(0, 16'd32767);
        write(8, 16'd1);
        @(negedge clk);
        check_all("ovf");
`ifdef FFT16_ST1_SCALE_EN
        check("ovf_y0", st1_yr[15:0], 16'd16384);
        check("ovf_y1", st1_yr[31:16], 16'd16383);
`else
        check("ovf_y0", st1_yr[15:0], 16'h8000);
`endif

        write(2, 16'd7);
        write(2, 16'hFFF0);
        @(negedge clk);
        check_all("rewrite");

        write(1, 16'd42);
        @(negedge clk);
        load = 1; addr_in = 4'd5; xr_in = 16'd1234;
        async_reset_check("mid_rst");
        @(negedge clk);
        load = 0;
        rst = 1;
        @(negedge clk);
        check_all("mid_rst_after");
        ramp("reramp");

        for (int t = 0; t < 40; t++) begin
            write($urandom_range(15, 0), 16'($urandom));
            @(negedge clk);
            check_all($sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
